pipelined_carry_adder: RTL
==========================

PIPELINED_CARRY_ADDER -- requirements
Module: pipelined_carry_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset, synchronous and active-high.
REQ-005 Port a, input, WIDTH, operand A.
REQ-006 Port b, input, WIDTH, operand B.
REQ-007 Port cin, input, 1, carry-in of the operation.
REQ-008 Port in_valid, input, 1, operands a/b/cin are valid this cycle.
REQ-009 Port in_ready, output, 1, block accepts an operation this cycle.
REQ-010 Port sum, output, WIDTH, result a+b+cin modulo 2^WIDTH.
REQ-011 Port cout, output, 1, carry-out of bit WIDTH-1.
REQ-012 Port out_valid, output, 1, sum/cout hold a valid result.
REQ-013 Port out_ready, input, 1, downstream consumes the result this cycle.

Function
REQ-014 The operation SHALL be accepted on a cycle where in_valid and in_ready are both high.
REQ-015 Stage k (0..STAGES-1) SHALL add chunk k of a and b plus the carry registered from stage k-1 (cin for stage 0), registering the chunk sum and carry.
REQ-016 Upper operand chunks SHALL travel forward in pipeline registers, and completed lower sum chunks SHALL be delayed, so that all chunks of one operation leave together.
REQ-017 Latency from acceptance to out_valid SHALL be exactly STAGES cycles when out_ready is held high.
REQ-018 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-019 Stall: in_ready = !(out_valid && !out_ready); while stalled, every pipeline register SHALL hold its value.
REQ-020 While out_valid is high and out_ready is low, sum and cout SHALL remain stable.
REQ-021 Bubbles (in_valid low) SHALL propagate as per-stage valid bits, and SHALL never produce out_valid.
REQ-022 Wrap-around: a carry out of bit WIDTH-1 SHALL appear only on cout, with sum modulo 2^WIDTH.
REQ-023 Acceptance and output consumption in the same cycle SHALL both take effect, with no lost or duplicated result.
REQ-024 Operations SHALL leave the block in acceptance order.

Reset
REQ-025 While rst is high, all stage valid bits SHALL clear, and out_valid=0, sum=0 and cout=0 SHALL hold; in-flight operations are discarded.
REQ-026 in_valid SHALL be ignored during any cycle in which rst is high.
REQ-027 On the first cycle after rst deasserts, in_ready SHALL be 1.

Configuration
REQ-028 With macro PCA_OVERFLOW_EN defined, output port ovf (1 bit) SHALL exist; it is aligned with sum and asserts when a and b have equal MSBs and the sum MSB differs (two's-complement overflow).
REQ-029 Without PCA_OVERFLOW_EN, port ovf and its pipeline registers SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package pca_pkg SHALL hold the default WIDTH/CHUNK constants and a function that computes STAGES.
REQ-031 Elaboration SHALL fail when WIDTH is not a multiple of CHUNK, or when CHUNK<1.
REQ-032 Sub-module chunk_adder (CHUNK-bit combinational a+b+cin, returning sum and cout) SHALL be instantiated once per stage.

Verification
REQ-033 The bench SHALL use WIDTH=16 and CHUNK=4; stimulus -> required response:
REQ-034 a=0x1234, b=0x1111, cin=0, out_ready=1 -> sum=0x2345, cout=0, out_valid exactly 4 cycles after acceptance.
REQ-035 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; with PCA_OVERFLOW_EN, ovf=0.
REQ-036 a=0x7FFF, b=0x0001, cin=0, PCA_OVERFLOW_EN defined -> sum=0x8000, cout=0, ovf=1.
REQ-037 Back-to-back stream of 8 operations i+i (i=0..7), with out_ready forced low for 3 cycles at result 2 -> in_ready low during the stall, sum/cout stable, all 8 results 0,2,...,14 delivered in order with none lost or duplicated.
REQ-038 rst pulsed for 1 cycle with 3 operations in flight -> out_valid=0 and sum=0 the next cycle, none of the 3 results ever emitted, in_ready=1 after reset.
REQ-039 a=0x0FFF, b=0x0000, cin=1 -> sum=0x1000, cout=0 (carry ripples across all stage boundaries).

Source files
------------

// File: rtl/pca_pkg.sv
// Shared constants and the stage-count helper for the pipelined carry adder.
package pca_pkg;

  localparam int PCA_WIDTH = 16;
  localparam int PCA_CHUNK = 4;

  function automatic int pca_stages(input int width, input int chunk);
    return (chunk > 0) ? width / chunk : 0;
  endfunction

endpackage

// File: rtl/pipelined_carry_adder_chunk_adder.sv
// Combinational CHUNK-bit adder slice: {cout, sum} = a + b + cin.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum   = total[CHUNK-1:0];
  assign cout  = total[CHUNK];

endmodule

// File: rtl/pipelined_carry_adder.sv
// Ripple-carry adder split into CHUNK-bit pipeline stages with a valid/ready handshake.
// Define PCA_OVERFLOW_EN to add the registered two's-complement overflow output ovf.
module pipelined_carry_adder
  import pca_pkg::*;
#(
  parameter int WIDTH = PCA_WIDTH,
  parameter int CHUNK = PCA_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef PCA_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STAGES = pca_stages(WIDTH, CHUNK);
  // Operand registers only feed stages 1..STAGES-1; keep at least one entry.
  localparam int AW = (STAGES > 1) ? STAGES - 1 : 1;

  if (CHUNK < 1) begin : g_bad_chunk
    $error("pipelined_carry_adder: CHUNK must be at least 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("pipelined_carry_adder: WIDTH must be a multiple of CHUNK");
  end

  logic             vld_q [STAGES];
  logic             cy_q  [STAGES];
  logic             cy_d  [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic [WIDTH-1:0] a_q   [AW];
  logic [WIDTH-1:0] b_q   [AW];
  logic             adv;

`ifdef PCA_OVERFLOW_EN
  logic ovf_q;
  logic ovf_d;
`endif

  assign adv       = !(vld_q[STAGES-1] && !out_ready);
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = cy_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic [CHUNK-1:0] cs;
    logic             ci;
    logic             co;
    logic [WIDTH-1:0] nxt;

    if (k == 0) begin : g_first
      assign ca = a[CHUNK-1:0];
      assign cb = b[CHUNK-1:0];
      assign ci = cin;
      always_comb begin
        nxt            = '0;
        nxt[CHUNK-1:0] = cs;
      end
    end else begin : g_rest
      assign ca = a_q[k-1][k*CHUNK +: CHUNK];
      assign cb = b_q[k-1][k*CHUNK +: CHUNK];
      assign ci = cy_q[k-1];
      // Lower chunks finished by earlier stages ride along unchanged.
      always_comb begin
        nxt                  = sum_q[k-1];
        nxt[k*CHUNK +: CHUNK] = cs;
      end
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a    (ca),
      .b    (cb),
      .cin  (ci),
      .sum  (cs),
      .cout (co)
    );

    assign sum_d[k] = nxt;
    assign cy_d[k]  = co;

`ifdef PCA_OVERFLOW_EN
    if (k == STAGES - 1) begin : g_ovf
      assign ovf_d = (ca[CHUNK-1] == cb[CHUNK-1]) && (cs[CHUNK-1] != ca[CHUNK-1]);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        sum_q[k] <= '0;
      end
      for (int k = 0; k < AW; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        cy_q[k]  <= cy_d[k];
        sum_q[k] <= sum_d[k];
      end
      a_q[0] <= a;
      b_q[0] <= b;
      for (int k = 1; k < AW; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
    end
  end

`ifdef PCA_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
